// File: rtl/uart_tx_fifo_feeder.sv
// uart_tx_fifo_feeder
//  Byte queue in front of the UART transmitter. Host bytes are buffered in a
//  2**DEPTH_LOG2 x 8 FIFO and handed to the transmitter one at a time. The
//  transmitter's done output paces the hand-off so frames chain back to back.
//
//  Optional feature macro: UART_TX_FIFO_OVF_FLAG_EN
//   defined     : o_Overflow is a sticky write-while-full flag, cleared by
//                 i_OvfClear (a new drop in the same cycle wins over the clear)
//   not defined : o_Overflow tied 0, i_OvfClear ignored
//
//  Ports
//   i_SysClock   system clock, rising edge
//   i_Reset      asynchronous active-high reset
//   i_WrValid    host write strobe (one byte per cycle)
//   i_WrByte     host write data
//   o_WrReady    high when a write would be accepted (!o_Full)
//   o_Full       queue holds 2**DEPTH_LOG2 entries
//   o_Empty      queue holds no entries
//   o_Level      number of entries stored
//   o_Busy       hand-off FSM active or queue not empty
//   o_Overflow   sticky dropped-write flag (see macro above)
//   i_OvfClear   clears o_Overflow
//   o_TxValid    valid to transmitter
//   o_TxByte     byte to transmitter, changes only on a pop
//   i_TxDone     transmitter done (high in its IDLE or STOP_BIT)
module uart_tx_fifo_feeder #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  i_SysClock,
    input  logic                  i_Reset,
    input  logic                  i_WrValid,
    input  logic [7:0]            i_WrByte,
    output logic                  o_WrReady,
    output logic                  o_Full,
    output logic                  o_Empty,
    output logic [DEPTH_LOG2:0]   o_Level,
    output logic                  o_Busy,
    output logic                  o_Overflow,
    input  logic                  i_OvfClear,
    output logic                  o_TxValid,
    output logic [7:0]            o_TxByte,
    input  logic                  i_TxDone
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2:0]   LEVEL_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2:0]   LEVEL_ZERO = {(DEPTH_LOG2+1){1'b0}};
    localparam logic [DEPTH_LOG2:0]   LEVEL_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_OFFER   = 2'd1,
        ST_SENDING = 2'd2
    } state_t;

    logic [7:0]            mem_r [DEPTH];
    logic [DEPTH_LOG2-1:0] wrPtr_r;
    logic [DEPTH_LOG2-1:0] rdPtr_r;
    logic [DEPTH_LOG2:0]   level_r;
    logic                  full_r;
    logic                  empty_r;
    logic                  busy_r;
    logic                  txValid_r;
    logic [7:0]            txByte_r;
    logic                  doneD_r;
    state_t                state_r;

    logic                  wrAccept_s;
    logic                  accept_s;
    logic                  pop_s;
    state_t                stateNext_s;
    logic [DEPTH_LOG2:0]   levelNext_s;

    // Full is judged on pre-edge state, so a write alongside a pop while full is dropped.
    assign wrAccept_s = i_WrValid && !full_r;
    // Transmitter took the byte when done falls (it left IDLE/STOP_BIT for START_BIT).
    assign accept_s   = doneD_r && !i_TxDone;

    // Hand-off FSM next state and pop decision.
    always_comb begin
        stateNext_s = state_r;
        pop_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!empty_r) begin
                    pop_s       = 1'b1;
                    stateNext_s = ST_OFFER;
                end else begin
                    stateNext_s = ST_IDLE;
                end
            end
            ST_OFFER: begin
                if (accept_s) begin
                    stateNext_s = ST_SENDING;
                end else begin
                    stateNext_s = ST_OFFER;
                end
            end
            ST_SENDING: begin
                // Done high here means STOP_BIT: queue the next byte so it chains.
                if (i_TxDone) begin
                    if (!empty_r) begin
                        pop_s       = 1'b1;
                        stateNext_s = ST_OFFER;
                    end else begin
                        stateNext_s = ST_IDLE;
                    end
                end else begin
                    stateNext_s = ST_SENDING;
                end
            end
            default: begin
                stateNext_s = ST_IDLE;
            end
        endcase
    end

    // Next fill level from simultaneous write/pop.
    always_comb begin
        levelNext_s = level_r;
        case ({wrAccept_s, pop_s})
            2'b10:   levelNext_s = level_r + LEVEL_ONE;
            2'b01:   levelNext_s = level_r - LEVEL_ONE;
            default: levelNext_s = level_r;
        endcase
    end

    // Storage array; contents need no reset since level gates every read.
    always_ff @(posedge i_SysClock) begin
        if (wrAccept_s) begin
            mem_r[wrPtr_r] <= i_WrByte;
        end
    end

    // Pointers, level, status flags, FSM state and transmitter outputs.
    always_ff @(posedge i_SysClock or posedge i_Reset) begin
        if (i_Reset) begin
            wrPtr_r   <= {DEPTH_LOG2{1'b0}};
            rdPtr_r   <= {DEPTH_LOG2{1'b0}};
            level_r   <= LEVEL_ZERO;
            full_r    <= 1'b0;
            empty_r   <= 1'b1;
            busy_r    <= 1'b0;
            txValid_r <= 1'b0;
            txByte_r  <= 8'h00;
            doneD_r   <= 1'b1;
            state_r   <= ST_IDLE;
        end else begin
            if (wrAccept_s) begin
                wrPtr_r <= wrPtr_r + PTR_ONE;
            end
            if (pop_s) begin
                rdPtr_r  <= rdPtr_r + PTR_ONE;
                txByte_r <= mem_r[rdPtr_r];
            end
            level_r   <= levelNext_s;
            full_r    <= (levelNext_s == LEVEL_FULL);
            empty_r   <= (levelNext_s == LEVEL_ZERO);
            busy_r    <= (stateNext_s != ST_IDLE) || (levelNext_s != LEVEL_ZERO);
            txValid_r <= (stateNext_s == ST_OFFER);
            doneD_r   <= i_TxDone;
            state_r   <= stateNext_s;
        end
    end

`ifdef UART_TX_FIFO_OVF_FLAG_EN
    logic ovf_r;
    logic wrDrop_s;

    assign wrDrop_s = i_WrValid && full_r;

    // Sticky overflow flag; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge i_SysClock or posedge i_Reset) begin
        if (i_Reset) begin
            ovf_r <= 1'b0;
        end else if (wrDrop_s) begin
            ovf_r <= 1'b1;
        end else if (i_OvfClear) begin
            ovf_r <= 1'b0;
        end else begin
            ovf_r <= ovf_r;
        end
    end

    assign o_Overflow = ovf_r;
`else
    logic unusedOvfClear_s;

    assign unusedOvfClear_s = i_OvfClear;
    assign o_Overflow       = 1'b0;
`endif

    assign o_WrReady = !full_r;
    assign o_Full    = full_r;
    assign o_Empty   = empty_r;
    assign o_Level   = level_r;
    assign o_Busy    = busy_r;
    assign o_TxValid = txValid_r;
    assign o_TxByte  = txByte_r;

endmodule

// File: tb/tb_uart_tx_fifo_feeder.sv
// tb_uart_tx_fifo_feeder
//  Directed bench for uart_tx_fifo_feeder. i_TxDone comes either from a
//  bench-driven stub or from a small behavioural UART transmitter
//  (8 clocks per bit) whose serial line is decoded to check framing.
module tb_uart_tx_fifo_feeder;

    localparam int DEPTH_LOG2 = 4;
`ifdef UART_TX_FIFO_OVF_FLAG_EN
    localparam logic OVF_EN = 1'b1;
`else
    localparam logic OVF_EN = 1'b0;
`endif

    logic                i_SysClock = 1'b0;
    logic                i_Reset;
    logic                i_WrValid;
    logic [7:0]          i_WrByte;
    logic                o_WrReady;
    logic                o_Full;
    logic                o_Empty;
    logic [DEPTH_LOG2:0] o_Level;
    logic                o_Busy;
    logic                o_Overflow;
    logic                i_OvfClear;
    logic                o_TxValid;
    logic [7:0]          o_TxByte;
    logic                i_TxDone;

    logic                stubDone;
    logic                useModel;

    int checks = 0;
    int errors = 0;

    always #5 i_SysClock = ~i_SysClock;

    uart_tx_fifo_feeder #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
        .i_SysClock (i_SysClock),
        .i_Reset    (i_Reset),
        .i_WrValid  (i_WrValid),
        .i_WrByte   (i_WrByte),
        .o_WrReady  (o_WrReady),
        .o_Full     (o_Full),
        .o_Empty    (o_Empty),
        .o_Level    (o_Level),
        .o_Busy     (o_Busy),
        .o_Overflow (o_Overflow),
        .i_OvfClear (i_OvfClear),
        .o_TxValid  (o_TxValid),
        .o_TxByte   (o_TxByte),
        .i_TxDone   (i_TxDone)
    );

    // Behavioural transmitter: IDLE=0 START=1 DATA=2 STOP=3, 8 clocks per bit.
    logic [1:0] txState;
    logic [2:0] clkCnt;
    logic [2:0] bitCnt;
    logic [7:0] shReg;
    logic       txLine;
    logic       modelDone;

    assign modelDone = (txState == 2'd0) || (txState == 2'd3);
    assign i_TxDone  = useModel ? modelDone : stubDone;
    assign txLine    = (txState == 2'd1) ? 1'b0 : (txState == 2'd2) ? shReg[0] : 1'b1;

    // Transmitter model state machine.
    always @(posedge i_SysClock or posedge i_Reset) begin
        if (i_Reset || !useModel) begin
            txState <= 2'd0;
            clkCnt  <= 3'd0;
            bitCnt  <= 3'd0;
            shReg   <= 8'h00;
        end else if (txState == 2'd0) begin
            if (o_TxValid) begin
                txState <= 2'd1;
                shReg   <= o_TxByte;
                clkCnt  <= 3'd0;
            end
        end else if (clkCnt != 3'd7) begin
            clkCnt <= clkCnt + 3'd1;
        end else begin
            clkCnt <= 3'd0;
            case (txState)
                2'd1: begin
                    txState <= 2'd2;
                    bitCnt  <= 3'd0;
                end
                2'd2: begin
                    shReg <= shReg >> 1;
                    if (bitCnt == 3'd7) txState <= 2'd3;
                    else bitCnt <= bitCnt + 3'd1;
                end
                default: begin
                    if (o_TxValid) begin
                        txState <= 2'd1;
                        shReg   <= o_TxByte;
                    end else begin
                        txState <= 2'd0;
                    end
                end
            endcase
        end
    end

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_SysClock);
        #1;
    endtask

    initial begin
        logic [7:0] rxByte;
        int         cnt;

        i_Reset    = 1'b1;
        i_WrValid  = 1'b0;
        i_WrByte   = 8'h00;
        i_OvfClear = 1'b0;
        stubDone   = 1'b1;
        useModel   = 1'b0;
        repeat (2) tick();
        i_Reset = 1'b0;
        tick();

        // Reset state
        checkEq("rst_level", o_Level, 0);
        checkEq("rst_empty", o_Empty, 1);
        checkEq("rst_full", o_Full, 0);
        checkEq("rst_wrready", o_WrReady, 1);
        checkEq("rst_txvalid", o_TxValid, 0);
        checkEq("rst_txbyte", o_TxByte, 8'h00);
        checkEq("rst_busy", o_Busy, 0);
        checkEq("rst_ovf", o_Overflow, 0);

        // Test 1: single byte, two-edge latency to offer
        i_WrValid = 1'b1;
        i_WrByte  = 8'hA5;
        tick();
        i_WrValid = 1'b0;
        checkEq("t1_level_after_wr", o_Level, 1);
        checkEq("t1_valid_early", o_TxValid, 0);
        tick();
        checkEq("t1_valid", o_TxValid, 1);
        checkEq("t1_byte", o_TxByte, 8'hA5);
        checkEq("t1_empty", o_Empty, 1);
        checkEq("t1_busy_offer", o_Busy, 1);
        stubDone = 1'b0;
        tick();
        checkEq("t1_valid_drop", o_TxValid, 0);
        checkEq("t1_byte_held", o_TxByte, 8'hA5);
        checkEq("t1_busy_sending", o_Busy, 1);

        // Test 2: fill to 16 with done held low, then overflow
        for (int i = 0; i < 16; i++) begin
            i_WrValid = 1'b1;
            i_WrByte  = 8'(i);
            tick();
        end
        i_WrValid = 1'b0;
        checkEq("t2_full", o_Full, 1);
        checkEq("t2_level", o_Level, 16);
        checkEq("t2_wrready", o_WrReady, 0);
        checkEq("t2_ovf_before", o_Overflow, 0);
        i_WrValid = 1'b1;
        i_WrByte  = 8'hFF;
        tick();
        i_WrValid = 1'b0;
        checkEq("t2_level_drop", o_Level, 16);
        checkEq("t2_ovf_set", o_Overflow, OVF_EN);
        tick();
        checkEq("t2_ovf_sticky", o_Overflow, OVF_EN);
        i_OvfClear = 1'b1;
        tick();
        i_OvfClear = 1'b0;
        checkEq("t2_ovf_clr", o_Overflow, 0);
        i_WrValid  = 1'b1;
        i_OvfClear = 1'b1;
        tick();
        i_WrValid  = 1'b0;
        i_OvfClear = 1'b0;
        checkEq("t2_ovf_set_wins", o_Overflow, OVF_EN);
        i_OvfClear = 1'b1;
        tick();
        i_OvfClear = 1'b0;

        // Test 4: write while full in the pop cycle is dropped
        stubDone  = 1'b1;
        i_WrValid = 1'b1;
        i_WrByte  = 8'h55;
        tick();
        i_WrValid = 1'b0;
        checkEq("t4_level", o_Level, 15);
        checkEq("t4_full", o_Full, 0);
        checkEq("t4_byte", o_TxByte, 8'h00);
        checkEq("t4_valid", o_TxValid, 1);
        checkEq("t4_ovf", o_Overflow, OVF_EN);
        tick();
        checkEq("t4_offer_hold", o_TxValid, 1);

        // Drain 11 bytes through accept/stop cycles; order must be preserved
        for (int k = 1; k <= 11; k++) begin
            stubDone = 1'b0;
            tick();
            checkEq("drain_valid_low", o_TxValid, 0);
            checkEq("drain_byte_held", o_TxByte, 8'(k - 1));
            stubDone = 1'b1;
            tick();
            checkEq("drain_byte", o_TxByte, 8'(k));
        end
        stubDone = 1'b0;
        tick();
        checkEq("t5_level_pre", o_Level, 4);
        checkEq("t5_valid_pre", o_TxValid, 0);

        // Test 5: asynchronous reset in SENDING
        #3;
        i_Reset = 1'b1;
        #1;
        checkEq("t5_level", o_Level, 0);
        checkEq("t5_empty", o_Empty, 1);
        checkEq("t5_full", o_Full, 0);
        checkEq("t5_txbyte", o_TxByte, 8'h00);
        checkEq("t5_busy", o_Busy, 0);
        checkEq("t5_ovf", o_Overflow, 0);
        tick();
        i_Reset  = 1'b0;
        stubDone = 1'b1;
        tick();
        i_WrValid = 1'b1;
        i_WrByte  = 8'h3C;
        tick();
        i_WrValid = 1'b0;
        tick();
        checkEq("t5_next_valid", o_TxValid, 1);
        checkEq("t5_next_byte", o_TxByte, 8'h3C);

        // Test 3: real transmitter, three chained frames
        i_Reset = 1'b1;
        tick();
        i_Reset  = 1'b0;
        useModel = 1'b1;
        tick();
        for (int i = 1; i <= 3; i++) begin
            i_WrValid = 1'b1;
            i_WrByte  = 8'(i);
            tick();
        end
        i_WrValid = 1'b0;
        for (int f = 0; f < 3; f++) begin
            cnt = 0;
            do begin
                @(negedge i_SysClock);
                cnt++;
            end while (txLine !== 1'b0 && cnt < 300);
            checkEq("t3_start_found", (cnt < 300), 1);
            repeat (4) @(negedge i_SysClock);
            checkEq("t3_start_bit", txLine, 0);
            for (int b = 0; b < 8; b++) begin
                repeat (8) @(negedge i_SysClock);
                rxByte[b] = txLine;
            end
            checkEq("t3_frame_data", rxByte, 8'(f + 1));
            repeat (8) @(negedge i_SysClock);
            checkEq("t3_stop_bit", txLine, 1);
            repeat (4) @(negedge i_SysClock);
            if (f < 2) checkEq("t3_chained_start", txLine, 0);
            else       checkEq("t3_line_idle", txLine, 1);
        end
        repeat (4) @(negedge i_SysClock);
        checkEq("t3_busy_end", o_Busy, 0);
        checkEq("t3_empty_end", o_Empty, 1);
        checkEq("t3_ovf_end", o_Overflow, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
